// File: rtl/imm_pkg.sv
// imm_pkg: immediate-type encodings and RISC-V immediate field positions
// shared by the immediate extractor and the pipelined immediate generator.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_t;

    // Instruction sign bit, replicated into every sign-extended immediate
    localparam int unsigned INS_SIGN  = 31;

    // I-type: ins[31:20]
    localparam int unsigned I_HI      = 31;
    localparam int unsigned I_LO      = 20;

    // S-type: {ins[31:25], ins[11:7]}
    localparam int unsigned S_HI_HI   = 31;
    localparam int unsigned S_HI_LO   = 25;
    localparam int unsigned S_LO_HI   = 11;
    localparam int unsigned S_LO_LO   = 7;

    // B-type: {ins[31], ins[7], ins[30:25], ins[11:8], 0}
    localparam int unsigned B_BIT11   = 7;
    localparam int unsigned B_HI_HI   = 30;
    localparam int unsigned B_HI_LO   = 25;
    localparam int unsigned B_LO_HI   = 11;
    localparam int unsigned B_LO_LO   = 8;

    // U-type: {ins[31:12], 12'b0}
    localparam int unsigned U_HI      = 31;
    localparam int unsigned U_LO      = 12;

    // J-type: {ins[31], ins[19:12], ins[20], ins[30:21], 0}
    localparam int unsigned J_MID_HI  = 19;
    localparam int unsigned J_MID_LO  = 12;
    localparam int unsigned J_BIT11   = 20;
    localparam int unsigned J_LO_HI   = 30;
    localparam int unsigned J_LO_LO   = 21;

endpackage

// File: rtl/imm_extract.sv
// imm_extract: combinational RISC-V immediate decoder. Builds the 32-bit
// immediate, then widens it to DATA_WIDTH (sign- or zero-extended for U-type
// according to SIGN_EXT_U). Types 6/7 flag oIllegal and yield zero.
module imm_extract
    import imm_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter bit SIGN_EXT_U = 1'b1
) (
    input  logic [31:0]           iInstruction,
    input  logic [2:0]            iInsType,
    output logic [DATA_WIDTH-1:0] oImm,
    output logic                  oIllegal
);

    logic [31:0] imm32;
    logic        sext;
    logic        s;

    assign s = iInstruction[INS_SIGN];

    // Select and assemble the 32-bit immediate for the given type
    always_comb begin
        imm32    = '0;
        sext     = 1'b1;
        oIllegal = 1'b0;
        case (iInsType)
            IMM_NONE: imm32 = '0;
            IMM_I:    imm32 = {{20{s}}, iInstruction[I_HI:I_LO]};
            IMM_S:    imm32 = {{20{s}}, iInstruction[S_HI_HI:S_HI_LO],
                               iInstruction[S_LO_HI:S_LO_LO]};
            IMM_B:    imm32 = {{19{s}}, s, iInstruction[B_BIT11],
                               iInstruction[B_HI_HI:B_HI_LO],
                               iInstruction[B_LO_HI:B_LO_LO], 1'b0};
            IMM_U: begin
                imm32 = {iInstruction[U_HI:U_LO], 12'b0};
                sext  = SIGN_EXT_U;
            end
            IMM_J:    imm32 = {{11{s}}, s, iInstruction[J_MID_HI:J_MID_LO],
                               iInstruction[J_BIT11],
                               iInstruction[J_LO_HI:J_LO_LO], 1'b0};
            default:  oIllegal = 1'b1;
        endcase
    end

    // Widen to the configured datapath width
    if (DATA_WIDTH > 32) begin : g_wide
        assign oImm = {{(DATA_WIDTH-32){sext & imm32[31]}}, imm32};
    end else begin : g_narrow
        assign oImm = imm32[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: one-cycle registered immediate generator with valid/ready
// handshakes on both sides and a flush input.
// Build option IMM_GEN_PIPE_SKID_EN: adds a one-entry skid buffer so that
// oReady is a registered signal (skid empty) with no combinational path from
// iReady. Without it, oReady = !oValid || iReady.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter bit SIGN_EXT_U = 1'b1
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iValid,
    output logic                  oReady,
    input  logic [31:0]           iInstruction,
    input  logic [2:0]            iInsType,
    input  logic                  iFlush,
    output logic                  oValid,
    input  logic                  iReady,
    output logic [DATA_WIDTH-1:0] oImm,
    output logic [2:0]            oInsType,
    output logic                  oIllegal
);

    logic [DATA_WIDTH-1:0] dec_imm;
    logic                  dec_ill;

    logic                  out_vld_q, out_vld_d;
    logic [DATA_WIDTH-1:0] out_imm_q, out_imm_d;
    logic [2:0]            out_type_q, out_type_d;
    logic                  out_ill_q, out_ill_d;

    logic                  in_hs;
    logic                  out_free;

    imm_extract #(
        .DATA_WIDTH (DATA_WIDTH),
        .SIGN_EXT_U (SIGN_EXT_U)
    ) u_extract (
        .iInstruction (iInstruction),
        .iInsType     (iInsType),
        .oImm         (dec_imm),
        .oIllegal     (dec_ill)
    );

    assign in_hs    = iValid && oReady;
    // Output register can take a new entry this cycle
    assign out_free = !out_vld_q || iReady;

`ifdef IMM_GEN_PIPE_SKID_EN
    logic                  skid_vld_q, skid_vld_d;
    logic [DATA_WIDTH-1:0] skid_imm_q, skid_imm_d;
    logic [2:0]            skid_type_q, skid_type_d;
    logic                  skid_ill_q, skid_ill_d;

    assign oReady = !skid_vld_q;

    // Next state: flush wins, then skid drains ahead of new input, then load/drain
    always_comb begin
        out_vld_d   = out_vld_q;
        out_imm_d   = out_imm_q;
        out_type_d  = out_type_q;
        out_ill_d   = out_ill_q;
        skid_vld_d  = skid_vld_q;
        skid_imm_d  = skid_imm_q;
        skid_type_d = skid_type_q;
        skid_ill_d  = skid_ill_q;
        if (iFlush) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (skid_vld_q) begin
            if (out_free) begin
                out_vld_d  = 1'b1;
                out_imm_d  = skid_imm_q;
                out_type_d = skid_type_q;
                out_ill_d  = skid_ill_q;
                skid_vld_d = 1'b0;
            end
        end else if (in_hs) begin
            if (out_free) begin
                out_vld_d  = 1'b1;
                out_imm_d  = dec_imm;
                out_type_d = iInsType;
                out_ill_d  = dec_ill;
            end else begin
                skid_vld_d  = 1'b1;
                skid_imm_d  = dec_imm;
                skid_type_d = iInsType;
                skid_ill_d  = dec_ill;
            end
        end else if (iReady) begin
            out_vld_d = 1'b0;
        end
    end

    // Skid entry storage
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            skid_vld_q  <= 1'b0;
            skid_imm_q  <= '0;
            skid_type_q <= IMM_NONE;
            skid_ill_q  <= 1'b0;
        end else begin
            skid_vld_q  <= skid_vld_d;
            skid_imm_q  <= skid_imm_d;
            skid_type_q <= skid_type_d;
            skid_ill_q  <= skid_ill_d;
        end
    end
`else
    assign oReady = out_free;

    // Next state: flush wins, then load (reload with no bubble), then drain
    always_comb begin
        out_vld_d  = out_vld_q;
        out_imm_d  = out_imm_q;
        out_type_d = out_type_q;
        out_ill_d  = out_ill_q;
        if (iFlush) begin
            out_vld_d = 1'b0;
        end else if (in_hs) begin
            out_vld_d  = 1'b1;
            out_imm_d  = dec_imm;
            out_type_d = iInsType;
            out_ill_d  = dec_ill;
        end else if (iReady) begin
            out_vld_d = 1'b0;
        end
    end
`endif

    // Output register
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            out_vld_q  <= 1'b0;
            out_imm_q  <= '0;
            out_type_q <= IMM_NONE;
            out_ill_q  <= 1'b0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_imm_q  <= out_imm_d;
            out_type_q <= out_type_d;
            out_ill_q  <= out_ill_d;
        end
    end

    assign oValid   = out_vld_q;
    assign oImm     = out_imm_q;
    assign oInsType = out_type_q;
    assign oIllegal = out_ill_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: table of decode vectors plus hand-written sequences
// for back-pressure, flush and reset. A scoreboard queue holds the expected
// output of every accepted instruction of the 32-bit DUT.
module tb_imm_gen_pipe;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  typ;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] ins;
        logic [2:0]  typ;
        logic [31:0] e32;
        logic [63:0] e64s;
        logic [63:0] e64z;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        iValid, iFlush, iReady;
    logic [31:0] iInstruction;
    logic [2:0]  iInsType;

    logic        oReady, oValid, oIllegal;
    logic [31:0] oImm;
    logic [2:0]  oInsType;

    logic        r64s, v64s, il64s, r64z, v64z, il64z;
    logic [63:0] imm64s, imm64z;
    logic [2:0]  t64s, t64z;

    int   tests = 0;
    int   fails = 0;
    int   n_out = 0;
    exp_t cur_exp;
    exp_t q[$];
    vec_t tv[11];

    always #5 clk = ~clk;

    imm_gen_pipe #(.DATA_WIDTH(32), .SIGN_EXT_U(1'b1)) dut (
        .iClk(clk), .iRst(rst), .iValid(iValid), .oReady(oReady),
        .iInstruction(iInstruction), .iInsType(iInsType), .iFlush(iFlush),
        .oValid(oValid), .iReady(iReady), .oImm(oImm), .oInsType(oInsType),
        .oIllegal(oIllegal));

    imm_gen_pipe #(.DATA_WIDTH(64), .SIGN_EXT_U(1'b1)) dut64s (
        .iClk(clk), .iRst(rst), .iValid(iValid), .oReady(r64s),
        .iInstruction(iInstruction), .iInsType(iInsType), .iFlush(iFlush),
        .oValid(v64s), .iReady(iReady), .oImm(imm64s), .oInsType(t64s),
        .oIllegal(il64s));

    imm_gen_pipe #(.DATA_WIDTH(64), .SIGN_EXT_U(1'b0)) dut64z (
        .iClk(clk), .iRst(rst), .iValid(iValid), .oReady(r64z),
        .iInstruction(iInstruction), .iInsType(iInsType), .iFlush(iFlush),
        .oValid(v64z), .iReady(iReady), .oImm(imm64z), .oInsType(t64z),
        .oIllegal(il64z));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: compare on output handshake, record on input handshake
    always @(negedge clk) begin
        if (rst || iFlush) begin
            q.delete();
        end else begin
            if (oValid && iReady) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got imm 0x%0h, expected no output", oImm);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_imm", {32'b0, oImm}, e.imm);
                    chk("sb_type", {61'b0, oInsType}, {61'b0, e.typ});
                    chk("sb_illegal", {63'b0, oIllegal}, {63'b0, e.ill});
                end
                n_out++;
            end
            if (iValid && oReady) q.push_back(cur_exp);
        end
    end

    task automatic drive(input logic [31:0] ins, input logic [2:0] typ, input logic [63:0] imm, input logic ill);
        iValid       = 1'b1;
        iInstruction = ins;
        iInsType     = typ;
        cur_exp      = '{imm: imm, typ: typ, ill: ill};
    endtask

    initial begin
        int   k;
        int   base;
        logic r0, r1;

        tv[0]  = '{32'hFFF00093, 3'd1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        tv[1]  = '{32'h0020A423, 3'd2, 32'h00000008, 64'h0000000000000008, 64'h0000000000000008, 1'b0};
        tv[2]  = '{32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        tv[3]  = '{32'h0010006F, 3'd5, 32'h00000800, 64'h0000000000000800, 64'h0000000000000800, 1'b0};
        tv[4]  = '{32'h123450B7, 3'd4, 32'h12345000, 64'h0000000012345000, 64'h0000000012345000, 1'b0};
        tv[5]  = '{32'h800000B7, 3'd4, 32'h80000000, 64'hFFFFFFFF80000000, 64'h0000000080000000, 1'b0};
        tv[6]  = '{32'hFFFFFFFF, 3'd0, 32'h00000000, 64'h0, 64'h0, 1'b0};
        tv[7]  = '{32'hFFF00093, 3'd7, 32'h00000000, 64'h0, 64'h0, 1'b1};
        tv[8]  = '{32'hFFF00093, 3'd6, 32'h00000000, 64'h0, 64'h0, 1'b1};
        tv[9]  = '{32'h7FF00013, 3'd1, 32'h000007FF, 64'h00000000000007FF, 64'h00000000000007FF, 1'b0};
        tv[10] = '{32'hFE000FA3, 3'd2, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};

        rst = 1'b1; iValid = 1'b0; iFlush = 1'b0; iReady = 1'b1;
        iInstruction = '0; iInsType = '0; cur_exp = '{imm: 64'h0, typ: 3'd0, ill: 1'b0};

        // Reset state
        #3;
        chk("rst_oValid", {63'b0, oValid}, 64'h0);
        chk("rst_oImm", {32'b0, oImm}, 64'h0);
        chk("rst_oInsType", {61'b0, oInsType}, 64'h0);
        chk("rst_oIllegal", {63'b0, oIllegal}, 64'h0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_oReady", {63'b0, oReady}, 64'h1);

        // Decode table, one instruction at a time with iReady high
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            drive(tv[i].ins, tv[i].typ, {32'b0, tv[i].e32}, tv[i].ill);
            @(posedge clk); #1 iValid = 1'b0;
            @(negedge clk);
            chk($sformatf("tv%0d_oValid", i), {63'b0, oValid}, 64'h1);
            chk($sformatf("tv%0d_imm64s", i), imm64s, tv[i].e64s);
            chk($sformatf("tv%0d_imm64z", i), imm64z, tv[i].e64z);
            chk($sformatf("tv%0d_ill64", i), {63'b0, il64s}, {63'b0, tv[i].ill});
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("tv_drained", {63'b0, oValid}, 64'h0);

        // Back-to-back 8 instructions with iReady toggling 1,0,1,0
        k = 0; base = n_out;
        for (int c = 0; c < 60 && (n_out - base) < 8; c++) begin
            @(posedge clk); #1;
            iReady = (c % 2 == 0);
            if (k < 8) drive({12'(k * 3 + 1), 20'h00013}, 3'd1, 64'(k * 3 + 1), 1'b0);
            else iValid = 1'b0;
            @(negedge clk);
            if (iValid && oReady) k++;
        end
        @(posedge clk); #1 iValid = 1'b0; iReady = 1'b1;
        chk("b2b_delivered", 64'(n_out - base), 64'd8);
        chk("b2b_queue_empty", 64'(q.size()), 64'd0);

        // Stall hold, then iReady->oReady path probe
        @(posedge clk); #1;
        iReady = 1'b0;
        drive(32'h12300013, 3'd1, 64'h123, 1'b0);
        @(posedge clk); #1 iValid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold_oValid", {63'b0, oValid}, 64'h1);
        chk("hold_oImm", {32'b0, oImm}, 64'h123);
        #2 r0 = oReady;
        iReady = 1'b1;
        #1 r1 = oReady;
        iReady = 1'b0;
`ifdef IMM_GEN_PIPE_SKID_EN
        chk("skid_oReady_stalled", {63'b0, r0}, 64'h1);
        chk("skid_oReady_no_comb", {63'b0, r1}, {63'b0, r0});
`else
        chk("oReady_stalled", {63'b0, r0}, 64'h0);
        chk("oReady_follows_iReady", {63'b0, r1}, 64'h1);
`endif

        // Reset pulsed mid-stall drops the held entry
        base = n_out;
        #1 rst = 1'b1;
        #1;
        chk("midrst_oValid", {63'b0, oValid}, 64'h0);
        chk("midrst_oImm", {32'b0, oImm}, 64'h0);
        @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0; iReady = 1'b1;
        @(negedge clk);
        chk("midrst_oReady", {63'b0, oReady}, 64'h1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("midrst_no_output", 64'(n_out - base), 64'd0);

        // Flush with output valid (and skid full when present) plus concurrent input
        @(posedge clk); #1;
        iReady = 1'b0;
        drive(32'h00100013, 3'd1, 64'h1, 1'b0);
        @(posedge clk); #1;
        drive(32'h00200013, 3'd1, 64'h2, 1'b0);
        @(posedge clk); #1;
        iFlush = 1'b1;
        drive(32'h00300013, 3'd1, 64'h3, 1'b0);
        base = n_out;
        @(posedge clk); #1;
        iFlush = 1'b0; iValid = 1'b0;
        @(negedge clk);
        chk("flush_oValid", {63'b0, oValid}, 64'h0);
        chk("flush_oReady", {63'b0, oReady}, 64'h1);
        #1 iReady = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("flush_no_output", 64'(n_out - base), 64'd0);
        chk("flush_oValid_after", {63'b0, oValid}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter: DATA_WIDTH, 32, immediate output width; legal values 32 or 64.
REQ-002 Parameter: SIGN_EXT_U, 1, 1 = U-type sign-extended above bit 32 when DATA_WIDTH=64; 0 = zero-extended.
REQ-003 Port: iClk  input  1  single clock, rising edge.
REQ-004 Port: iRst  input  1  asynchronous, active-high reset.
REQ-005 Port: iValid  input  1  upstream instruction valid.
REQ-006 Port: oReady  output  1  block accepts an instruction this cycle.
REQ-007 Port: iInstruction  input  32  raw instruction word.
REQ-008 Port: iInsType  input  3  imm_type_t (NONE=0, I=1, S=2, B=3, U=4, J=5; 6-7 illegal).
REQ-009 Port: iFlush  input  1  discard all held entries.
REQ-010 Port: oValid  output  1  oImm/oInsType valid.
REQ-011 Port: iReady  input  1  downstream accepts output.
REQ-012 Port: oImm  output  DATA_WIDTH  decoded immediate.
REQ-013 Port: oInsType  output  3  type carried with oImm.
REQ-014 Port: oIllegal  output  1  iInsType was 6 or 7; oImm forced to 0.

Function
REQ-015 Transfer in when iValid&&oReady; transfer out when oValid&&iReady.
REQ-016 Immediate: I = sext(ins[31:20]); S = sext({ins[31:25],ins[11:7]}); B = sext({ins[31],ins[7],ins[30:25],ins[11:8],1'b0}); U = {ins[31:12],12'b0}, upper bits per SIGN_EXT_U; J = sext({ins[31],ins[19:12],ins[20],ins[30:21],1'b0}); NONE = 0.
REQ-017 Decode is combinational into one output register; latency exactly 1 cycle from input handshake to oValid.
REQ-018 Output register holds oImm/oInsType/oIllegal stable while oValid&&!iReady.
REQ-019 Without skid (see REQ-026): oReady = !oValid || iReady; same-cycle input and output handshakes reload the register with no bubble.
REQ-020 iFlush clears oValid (and skid entry) next cycle; input handshake in the flush cycle is discarded; oReady during flush follows the normal rule.
REQ-021 iFlush has priority over every simultaneous load or drain.
REQ-022 Type 6/7 inputs are accepted, produce oIllegal=1, oImm=0, oInsType unchanged.

Reset
REQ-023 On iRst assertion, asynchronously: oValid=0, oImm=0, oInsType=NONE, oIllegal=0, skid entry empty.
REQ-024 oReady=1 on the first cycle after iRst deasserts.
REQ-025 Reset mid-transfer drops the in-flight entry; no output handshake for it occurs.

Configuration
REQ-026 Macro IMM_GEN_PIPE_SKID_EN defined: one-entry skid buffer added; oReady is a register output (=skid empty), no combinational iReady->oReady path; full throughput preserved; entry written to skid when output stalled and input handshakes; skid drains to output before new input.
REQ-027 Macro undefined: no skid storage; oReady per REQ-019.
REQ-028 Ordering is strictly FIFO in both configurations.

Structure
REQ-029 Package imm_pkg holds imm_type_t, its encodings and the immediate field bit-position constants.
REQ-030 Sub-module imm_extract (combinational, parametrised on DATA_WIDTH) performs REQ-016; imm_gen_pipe instantiates it once (twice storage-wise not needed).
REQ-031 No latches; all state on iClk with async iRst.

Verification
REQ-032 I, 0xFFF00093, iReady=1 -> next cycle oValid=1, oImm=0xFFFFFFFF.
REQ-033 S 0x0020A423 -> oImm=8; B 0xFE000EE3 -> oImm=0xFFFFFFFC; J 0x0010006F -> oImm=0x800.
REQ-034 U 0x123450B7, DATA_WIDTH=64 -> oImm=0x0000000012345000; U 0x800000B7, SIGN_EXT_U=1 -> 0xFFFFFFFF80000000, SIGN_EXT_U=0 -> 0x0000000080000000.
REQ-035 Back-to-back 8 instructions, iReady toggled 1,0,1,0 -> all 8 delivered in order, none lost or duplicated, both macro settings; SKID_EN shows no combinational iReady->oReady dependency.
REQ-036 iFlush with oValid=1 and skid full plus concurrent input -> next cycle oValid=0, oReady=1, no further outputs.
REQ-037 iInsType=7 -> oIllegal=1, oImm=0; iRst pulsed mid-stall -> all outputs zero immediately, oReady=1 after release.
